// File: rtl/render_scheduler.sv
// render_scheduler -- sequences one video frame: grid drawer, then sprite
// drawer, and multiplexes the active drawer's pixel port onto the VGA adapter.
//
// Optional feature: define FRAME_CLEAR_EN to add a CLEAR state that blanks the
// 160x120 frame buffer (colour 0, one pixel per cycle) before the grid pass.
//
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   frame_tick                    one-cycle request for a new frame
//   grid_start / grid_done        handshake with the grid drawer
//   grid_vga_*                    grid drawer pixel port
//   sprite_start / sprite_done    handshake with the sprite drawer
//   sprite_vga_*                  sprite drawer pixel port
//   vga_x/y/colour/write          muxed pixel port to the VGA adapter
//   busy                          high whenever not IDLE
//   frame_done                    one-cycle pulse at frame completion
//   frame_count                   completed frames (wrapping)
//   overrun_count                 dropped frame ticks (saturating)
module render_scheduler (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  output logic       grid_start,
  input  logic       grid_done,
  input  logic [7:0] grid_vga_x,
  input  logic [6:0] grid_vga_y,
  input  logic [2:0] grid_vga_colour,
  input  logic       grid_vga_write,
  output logic       sprite_start,
  input  logic       sprite_done,
  input  logic [7:0] sprite_vga_x,
  input  logic [6:0] sprite_vga_y,
  input  logic [2:0] sprite_vga_colour,
  input  logic       sprite_vga_write,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic [7:0] overrun_count
);

`ifdef FRAME_CLEAR_EN
  typedef enum logic [2:0] {
    IDLE, CLEAR, START_GRID, WAIT_GRID, START_SPRITE, WAIT_SPRITE, FRAME_DONE
  } state_t;
  localparam state_t FRAME_ENTRY = CLEAR;
`else
  typedef enum logic [2:0] {
    IDLE, START_GRID, WAIT_GRID, START_SPRITE, WAIT_SPRITE, FRAME_DONE
  } state_t;
  localparam state_t FRAME_ENTRY = START_GRID;
`endif

  state_t state, next_state;
  logic   pending;

`ifdef FRAME_CLEAR_EN
  logic [7:0] clear_x;
  logic [6:0] clear_y;
  logic       clear_last;

  assign clear_last = (clear_x == 8'd159) && (clear_y == 7'd119);

  // Raster sweep, x inner; counters return to 0 on the last pixel so the
  // next CLEAR pass starts at the origin.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_x <= '0;
      clear_y <= '0;
    end else if (state == CLEAR) begin
      if (clear_x == 8'd159) begin
        clear_x <= '0;
        clear_y <= clear_last ? 7'd0 : clear_y + 7'd1;
      end else begin
        clear_x <= clear_x + 8'd1;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:         if (frame_tick) next_state = FRAME_ENTRY;
`ifdef FRAME_CLEAR_EN
      CLEAR:        if (clear_last) next_state = START_GRID;
`endif
      START_GRID:   next_state = WAIT_GRID;
      WAIT_GRID:    if (grid_done) next_state = START_SPRITE;
      START_SPRITE: next_state = WAIT_SPRITE;
      WAIT_SPRITE:  if (sprite_done) next_state = FRAME_DONE;
      // A tick arriving in FRAME_DONE starts the next frame directly.
      FRAME_DONE:   next_state = (pending || frame_tick) ? FRAME_ENTRY : IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Pending request, frame and overrun counters
  always_ff @(posedge clock) begin
    if (reset) begin
      pending       <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      // FRAME_DONE consumes the pending request (or the simultaneous tick).
      if (state == FRAME_DONE)
        pending <= 1'b0;
      else if (frame_tick && state != IDLE)
        pending <= 1'b1;

      if (frame_tick && state != IDLE && pending && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;

      if (state == WAIT_SPRITE && sprite_done)
        frame_count <= frame_count + 8'd1;
    end
  end

  // Output logic; outputs are forced low while reset is held.
  always_comb begin
    grid_start   = 1'b0;
    sprite_start = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b0;
    vga_x        = '0;
    vga_y        = '0;
    vga_colour   = '0;
    vga_write    = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
`ifdef FRAME_CLEAR_EN
        CLEAR: begin
          vga_x     = clear_x;
          vga_y     = clear_y;
          vga_write = 1'b1;
        end
`endif
        START_GRID:   grid_start = 1'b1;
        WAIT_GRID: begin
          vga_x      = grid_vga_x;
          vga_y      = grid_vga_y;
          vga_colour = grid_vga_colour;
          vga_write  = grid_vga_write;
        end
        START_SPRITE: sprite_start = 1'b1;
        WAIT_SPRITE: begin
          vga_x      = sprite_vga_x;
          vga_y      = sprite_vga_y;
          vga_colour = sprite_vga_colour;
          vga_write  = sprite_vga_write;
        end
        FRAME_DONE:   frame_done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_render_scheduler.sv
module tb_render_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       grid_start, grid_done = 1'b0;
  logic [7:0] grid_vga_x = '0;
  logic [6:0] grid_vga_y = '0;
  logic [2:0] grid_vga_colour = '0;
  logic       grid_vga_write = 1'b0;
  logic       sprite_start, sprite_done = 1'b0;
  logic [7:0] sprite_vga_x = '0;
  logic [6:0] sprite_vga_y = '0;
  logic [2:0] sprite_vga_colour = '0;
  logic       sprite_vga_write = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write, busy, frame_done;
  logic [7:0] frame_count, overrun_count;

  always #5 clock = ~clock;

  render_scheduler dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .grid_start(grid_start), .grid_done(grid_done),
    .grid_vga_x(grid_vga_x), .grid_vga_y(grid_vga_y),
    .grid_vga_colour(grid_vga_colour), .grid_vga_write(grid_vga_write),
    .sprite_start(sprite_start), .sprite_done(sprite_done),
    .sprite_vga_x(sprite_vga_x), .sprite_vga_y(sprite_vga_y),
    .sprite_vga_colour(sprite_vga_colour), .sprite_vga_write(sprite_vga_write),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
    .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  typedef struct packed {
    logic       busy, gs, ss, fd, vw;
    logic [7:0] vx;
    logic [6:0] vy;
    logic [2:0] vc;
    logic [7:0] fc, oc;
  } obs_t;

  typedef struct packed {
    logic       tick, gd, sd;
    logic       gw;
    logic [7:0] gx;
    logic [6:0] gy;
    logic [2:0] gc;
    logic       sw;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] sc;
    obs_t       exp;
  } vec_t;

  obs_t sb_q[$];
  int   sb_id[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  function automatic obs_t observe();
    return {busy, grid_start, sprite_start, frame_done, vga_write,
            vga_x, vga_y, vga_colour, frame_count, overrun_count};
  endfunction

  function automatic vec_t mk(int tick, int gd, int sd,
                              int gw, int gx, int gy, int gc,
                              int sw, int sx, int sy, int sc,
                              int b, int gs, int ss, int fd,
                              int vw, int vx, int vy, int vc, int fc, int oc);
    vec_t v;
    v.tick = 1'(tick); v.gd = 1'(gd); v.sd = 1'(sd);
    v.gw = 1'(gw); v.gx = 8'(gx); v.gy = 7'(gy); v.gc = 3'(gc);
    v.sw = 1'(sw); v.sx = 8'(sx); v.sy = 7'(sy); v.sc = 3'(sc);
    v.exp.busy = 1'(b); v.exp.gs = 1'(gs); v.exp.ss = 1'(ss); v.exp.fd = 1'(fd);
    v.exp.vw = 1'(vw); v.exp.vx = 8'(vx); v.exp.vy = 7'(vy); v.exp.vc = 3'(vc);
    v.exp.fc = 8'(fc); v.exp.oc = 8'(oc);
    return v;
  endfunction

  // Scoreboard consumer: the outputs of a table row are sampled mid-cycle.
  always @(negedge clock) begin
    obs_t e, a;
    int   id;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      id = sb_id.pop_front();
      a  = observe();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got %h expected %h", id, a, e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    frame_tick = 0; grid_done = 0; sprite_done = 0;
    grid_vga_x = '0; grid_vga_y = '0; grid_vga_colour = '0; grid_vga_write = 0;
    sprite_vga_x = '0; sprite_vga_y = '0; sprite_vga_colour = '0; sprite_vga_write = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    check("reset_outputs", 32'(observe()), 0);
    step();
    reset = 0;
    cyc = 0;
  endtask

  task automatic wait_sprite_start(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (sprite_start) begin seen = 1; break; end
      step();
    end
    check("wait_sprite_start", 32'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[27];
    int   seen_fd;

    tv[0]  = mk(0,0,0, 0,0,0,0,      0,0,0,0,       0,0,0,0, 0,0,0,0,       0,0);
    tv[1]  = mk(0,1,1, 1,37,0,0,     1,99,0,0,      0,0,0,0, 0,0,0,0,       0,0);
    tv[2]  = mk(1,0,0, 0,0,0,0,      0,0,0,0,       0,0,0,0, 0,0,0,0,       0,0);
    tv[3]  = mk(0,1,0, 0,0,0,0,      0,0,0,0,       1,1,0,0, 0,0,0,0,       0,0);
    tv[4]  = mk(0,0,0, 1,37,5,3,     1,99,9,7,      1,0,0,0, 1,37,5,3,      0,0);
    tv[5]  = mk(0,0,1, 0,12,0,0,     1,99,0,0,      1,0,0,0, 0,12,0,0,      0,0);
    tv[6]  = mk(0,1,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       0,0);
    tv[7]  = mk(0,0,1, 0,0,0,0,      0,0,0,0,       1,0,1,0, 0,0,0,0,       0,0);
    tv[8]  = mk(0,1,0, 1,1,1,1,      1,150,119,5,   1,0,0,0, 1,150,119,5,   0,0);
    tv[9]  = mk(0,0,1, 0,0,0,0,      0,2,0,0,       1,0,0,0, 0,2,0,0,       0,0);
    tv[10] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,1, 0,0,0,0,       1,0);
    tv[11] = mk(1,0,0, 0,0,0,0,      0,0,0,0,       0,0,0,0, 0,0,0,0,       1,0);
    tv[12] = mk(1,0,0, 0,0,0,0,      0,0,0,0,       1,1,0,0, 0,0,0,0,       1,0);
    tv[13] = mk(1,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       1,0);
    tv[14] = mk(1,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       1,1);
    tv[15] = mk(0,1,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       1,2);
    tv[16] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,0,1,0, 0,0,0,0,       1,2);
    tv[17] = mk(0,0,1, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       1,2);
    tv[18] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,1, 0,0,0,0,       2,2);
    tv[19] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,1,0,0, 0,0,0,0,       2,2);
    tv[20] = mk(1,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       2,2);
    tv[21] = mk(1,1,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       2,2);
    tv[22] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,0,1,0, 0,0,0,0,       2,3);
    tv[23] = mk(0,0,1, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       2,3);
    tv[24] = mk(1,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,1, 0,0,0,0,       3,3);
    tv[25] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,1,0,0, 0,0,0,0,       3,4);
    tv[26] = mk(0,0,0, 0,0,0,0,      0,0,0,0,       1,0,0,0, 0,0,0,0,       3,4);

    do_reset();

`ifndef FRAME_CLEAR_EN
    // Table: each row's inputs are applied for one cycle and the outputs
    // observed in that same cycle.
    for (int i = 0; i < 27; i++) begin
      step();
      frame_tick = tv[i].tick; grid_done = tv[i].gd; sprite_done = tv[i].sd;
      grid_vga_write = tv[i].gw; grid_vga_x = tv[i].gx;
      grid_vga_y = tv[i].gy; grid_vga_colour = tv[i].gc;
      sprite_vga_write = tv[i].sw; sprite_vga_x = tv[i].sx;
      sprite_vga_y = tv[i].sy; sprite_vga_colour = tv[i].sc;
      sb_q.push_back(tv[i].exp);
      sb_id.push_back(i);
    end
    step();
    clear_inputs();
    step();

    // Frame timing: tick at cycle 10, grid_done at 50, sprite_done at 80.
    do_reset();
    while (cyc < 10) step();
    frame_tick = 1;
    step();
    frame_tick = 0;
    check("c11_grid_start", 32'(grid_start), 1);
    check("c11_busy", 32'(busy), 1);
    step();
    check("c12_grid_start", 32'(grid_start), 0);
    while (cyc < 50) step();
    grid_done = 1;
    step();
    grid_done = 0;
    check("c51_sprite_start", 32'(sprite_start), 1);
    step();
    check("c52_sprite_start", 32'(sprite_start), 0);
    while (cyc < 80) step();
    sprite_done = 1;
    step();
    sprite_done = 0;
    check("c81_frame_done", 32'(frame_done), 1);
    check("c81_frame_count", 32'(frame_count), 1);
    step();
    check("c82_frame_done", 32'(frame_done), 0);
    check("c82_busy", 32'(busy), 0);
    check("c82_frame_count", 32'(frame_count), 1);

    // Overrun saturation: tick held for 301 cycles starting in IDLE.
    do_reset();
    frame_tick = 1;
    for (int i = 0; i < 301; i++) step();
    frame_tick = 0;
    check("overrun_sat", 32'(overrun_count), 255);
    check("overrun_busy", 32'(busy), 1);
    grid_done = 1;
    step();
    grid_done = 0;
    wait_sprite_start(5);
    step();
    sprite_done = 1;
    step();
    sprite_done = 0;
    check("pend_frame_done", 32'(frame_done), 1);
    step();
    check("pend_restart", 32'(grid_start), 1);
    check("pend_overrun", 32'(overrun_count), 255);

    // Reset in WAIT_SPRITE abandons the frame.
    step();
    grid_done = 1;
    step();
    grid_done = 0;
    wait_sprite_start(5);
    step();
    check("ws_busy", 32'(busy), 1);
    reset = 1;
    step();
    reset = 0;
    check("rst_ws_busy", 32'(busy), 0);
    check("rst_ws_counts", 32'({frame_count, overrun_count}), 0);
    seen_fd = 0;
    sprite_done = 1;
    for (int i = 0; i < 5; i++) begin
      if (frame_done || busy) seen_fd++;
      step();
    end
    sprite_done = 0;
    check("rst_ws_quiet", 32'(seen_fd), 0);
`else
    begin
      int     writes = 0;
      int     bad_px = 0;
      int     ex = 0;
      int     ey = 0;
      int     lx = -1;
      int     ly = -1;
      bit     started = 0;
      frame_tick = 1;
      step();
      frame_tick = 0;
      for (int i = 0; i < 20000; i++) begin
        if (grid_start) begin started = 1; break; end
        if (vga_write) begin
          if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != 3'd0) bad_px++;
          lx = int'(vga_x); ly = int'(vga_y);
          writes++;
          if (ex == 159) begin ex = 0; ey++; end else ex++;
        end
        step();
      end
      check("clear_started_grid", 32'(started), 1);
      check("clear_writes", 32'(writes), 19200);
      check("clear_bad_pixels", 32'(bad_px), 0);
      check("clear_last_x", 32'(lx), 159);
      check("clear_last_y", 32'(ly), 119);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
